// File: rtl/cache_wb_dm_pkg.sv
`default_nettype none
// ============================================================================
// Package : cache_wb_dm_pkg
// Shared state encoding and address-field width helpers for cache_wb_dm.
// Rev     : 1.0
// ============================================================================

package cache_wb_dm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] S_WB         = 3'd1;
    localparam logic [STATE_W-1:0] S_FILL       = 3'd2;
    localparam logic [STATE_W-1:0] S_FLUSH_SCAN = 3'd3;
    localparam logic [STATE_W-1:0] S_FLUSH_WB   = 3'd4;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int words);
        return addr_w - 2 - $clog2(words) - $clog2(lines);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_wb_dm_mem_seq.sv
`default_nettype none
// ============================================================================
// Module : cache_wb_dm_mem_seq
// Word counter, request/acknowledge sequencer and address generator for
// line write-back and fill transfers.
// Rev    : 1.0
// ============================================================================

module cache_wb_dm_mem_seq #(
    parameter int ADDR_W = 12,
    parameter int WORDS  = 4,
    parameter int OFF_W  = 2,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              active_i,
    input  logic              wr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [31:0]       wdata_i,
    input  logic              ack_i,
    output logic              req_o,
    output logic              wen_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       dout_o,
    output logic [OFF_W-1:0]  word_o,
    output logic              ack_o,
    output logic              last_o
);

    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    logic [OFF_W-1:0] word_q;
    logic [OFF_W-1:0] word_d;
    logic             w_go;

    // Reset masks the request combinationally so an abandoned transfer drops at once.
    assign w_go   = active_i & ~rst_i;
    assign req_o  = w_go;
    assign wen_o  = ~(w_go & wr_i);
    assign addr_o = w_go ? {tag_i, idx_i, word_q, 2'b00} : '0;
    assign dout_o = (w_go & wr_i) ? wdata_i : 32'd0;
    assign ack_o  = w_go & ack_i;
    assign last_o = ack_o & (word_q == LAST_WORD);
    assign word_o = word_q;

    always_comb begin
        word_d = word_q;
        if (ack_o) begin
            word_d = (word_q == LAST_WORD) ? '0 : word_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_wb_dm.sv
`default_nettype none
// ============================================================================
// Module : cache_wb_dm
// Direct-mapped, write-back, write-allocate data cache with a word-serial
// request/acknowledge memory port, flush walk and hit/miss counters.
// Rev    : 1.0
// ============================================================================

module cache_wb_dm
    import cache_wb_dm_pkg::*;
#(
    parameter int LINES  = 8,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              C_CSN,
    input  logic              C_WEN,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [31:0]       C_DI,
    output logic [31:0]       C_DOUT,
    output logic              STALL,
    input  logic              FLUSH,
    output logic              FLUSH_BUSY,
    output logic              M_REQ,
    output logic              M_WEN,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [31:0]       M_DOUT,
    input  logic [31:0]       M_DI,
    input  logic              M_ACK,
    output logic [15:0]       HIT_CNT,
    output logic [15:0]       MISS_CNT
);

    localparam int OFF_W = off_w(WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS);
    localparam int DEPTH = LINES * WORDS;
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(LINES - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   line_q, line_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic               pend_q, pend_d;
    logic [15:0]        hit_q, hit_d;
    logic [15:0]        miss_q, miss_d;

    logic [TAG_W-1:0]   tags_q [LINES];
    logic [31:0]        data_q [DEPTH];

    logic [OFF_W-1:0]   w_req_off;
    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [1:0]         w_unused_byte;
    logic               w_hit;
    logic               w_done;
    logic               w_active;
    logic               w_wr;
    logic [TAG_W-1:0]   w_seq_tag;
    logic [31:0]        w_seq_wdata;
    logic [OFF_W-1:0]   w_word;
    logic               w_ack;
    logic               w_last;
    logic [IDX_W-1:0]   w_next_line;
    logic               w_data_we;
    logic [IDX_W+OFF_W-1:0] w_data_addr;
    logic [31:0]        w_data_wdata;
    logic               w_tag_we;

    assign w_req_off     = C_ADDR[2 +: OFF_W];
    assign w_req_idx     = C_ADDR[2 + OFF_W +: IDX_W];
    assign w_req_tag     = C_ADDR[ADDR_W-1 -: TAG_W];
    assign w_unused_byte = C_ADDR[1:0];

    assign w_hit  = valid_q[w_req_idx] && (tags_q[w_req_idx] == w_req_tag);
    assign w_done = (state_q == S_IDLE) && !C_CSN && w_hit;

    assign w_active    = (state_q == S_WB) || (state_q == S_FILL) || (state_q == S_FLUSH_WB);
    assign w_wr        = (state_q != S_FILL);
    // Write-back addresses the resident tag; a fill addresses the latched request tag.
    assign w_seq_tag   = (state_q == S_FILL) ? tag_q : tags_q[line_q];
    assign w_seq_wdata = data_q[{line_q, w_word}];
    assign w_next_line = line_q + 1'b1;

    cache_wb_dm_mem_seq #(
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS),
        .OFF_W  (OFF_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_mem_seq (
        .clk_i    (CLK),
        .rst_i    (RST),
        .active_i (w_active),
        .wr_i     (w_wr),
        .tag_i    (w_seq_tag),
        .idx_i    (line_q),
        .wdata_i  (w_seq_wdata),
        .ack_i    (M_ACK),
        .req_o    (M_REQ),
        .wen_o    (M_WEN),
        .addr_o   (M_ADDR),
        .dout_o   (M_DOUT),
        .word_o   (w_word),
        .ack_o    (w_ack),
        .last_o   (w_last)
    );

    assign STALL      = !RST && !C_CSN && !w_done;
    assign C_DOUT     = (!RST && w_done && C_WEN) ? data_q[{w_req_idx, w_req_off}] : 32'd0;
    assign FLUSH_BUSY = !RST && ((state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB));
    assign HIT_CNT    = RST ? 16'd0 : hit_q;
    assign MISS_CNT   = RST ? 16'd0 : miss_q;

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        pend_d       = pend_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        w_data_we    = 1'b0;
        w_data_addr  = {w_req_idx, w_req_off};
        w_data_wdata = C_DI;
        w_tag_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!C_CSN) begin
                    if (w_hit) begin
                        if (!C_WEN) begin
                            w_data_we          = 1'b1;
                            dirty_d[w_req_idx] = 1'b1;
                        end
                        if (!pend_q) begin
                            hit_d = sat_inc(hit_q);
                        end
                        pend_d = 1'b0;
                    end else begin
                        miss_d  = sat_inc(miss_q);
                        line_d  = w_req_idx;
                        tag_d   = w_req_tag;
                        state_d = (valid_q[w_req_idx] && dirty_q[w_req_idx]) ? S_WB : S_FILL;
                    end
                end else if (FLUSH) begin
                    line_d  = '0;
                    state_d = dirty_q[0] ? S_FLUSH_WB : S_FLUSH_SCAN;
                end
            end

            S_WB: begin
                if (w_last) begin
                    state_d = S_FILL;
                end
            end

            S_FILL: begin
                if (w_ack) begin
                    w_data_we    = 1'b1;
                    w_data_addr  = {line_q, w_word};
                    w_data_wdata = M_DI;
                end
                if (w_last) begin
                    valid_d[line_q] = 1'b1;
                    dirty_d[line_q] = 1'b0;
                    w_tag_we        = 1'b1;
                    state_d         = S_IDLE;
                end
            end

            // Clean lines cost one cycle; dirty lines go straight into write-back.
            S_FLUSH_SCAN: begin
                if (line_q == LAST_LINE) begin
                    state_d = S_IDLE;
                end else begin
                    line_d  = w_next_line;
                    state_d = dirty_q[w_next_line] ? S_FLUSH_WB : S_FLUSH_SCAN;
                end
            end

            S_FLUSH_WB: begin
                if (w_last) begin
                    dirty_d[line_q] = 1'b0;
                    if (line_q == LAST_LINE) begin
                        state_d = S_IDLE;
                    end else begin
                        line_d  = w_next_line;
                        state_d = dirty_q[w_next_line] ? S_FLUSH_WB : S_FLUSH_SCAN;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any stalled access forfeits its hit count when it finally completes.
        if (STALL) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            pend_q  <= 1'b0;
            hit_q   <= 16'd0;
            miss_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            pend_q  <= pend_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_data_we) begin
            data_q[w_data_addr] <= w_data_wdata;
        end
        if (w_tag_we) begin
            tags_q[line_q] <= tag_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_wb_dm.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_wb_dm
// Directed self-checking bench for cache_wb_dm with a delayed-ACK memory model.
// Rev    : 1.0
// ============================================================================

module tb_cache_wb_dm;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        C_CSN = 1'b1;
    logic        C_WEN = 1'b1;
    logic [11:0] C_ADDR = '0;
    logic [31:0] C_DI = '0;
    logic        FLUSH = 1'b0;
    logic [31:0] C_DOUT;
    logic        STALL;
    logic        FLUSH_BUSY;
    logic        M_REQ;
    logic        M_WEN;
    logic [11:0] M_ADDR;
    logic [31:0] M_DOUT;
    logic [31:0] M_DI;
    logic        M_ACK;
    logic [15:0] HIT_CNT;
    logic [15:0] MISS_CNT;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];
    bit          mem_init = 1'b0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          unstable = 0;
    logic [11:0] held_addr = '0;
    logic [11:0] la [$];
    logic        lw [$];
    logic [31:0] ld [$];

    always #5 CLK = ~CLK;

    cache_wb_dm #(.LINES(8), .WORDS(4), .ADDR_W(12)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_CSN      (C_CSN),
        .C_WEN      (C_WEN),
        .C_ADDR     (C_ADDR),
        .C_DI       (C_DI),
        .C_DOUT     (C_DOUT),
        .STALL      (STALL),
        .FLUSH      (FLUSH),
        .FLUSH_BUSY (FLUSH_BUSY),
        .M_REQ      (M_REQ),
        .M_WEN      (M_WEN),
        .M_ADDR     (M_ADDR),
        .M_DOUT     (M_DOUT),
        .M_DI       (M_DI),
        .M_ACK      (M_ACK),
        .HIT_CNT    (HIT_CNT),
        .MISS_CNT   (MISS_CNT)
    );

    assign M_ACK = M_REQ && (ack_cnt >= ack_delay);
    assign M_DI  = mem[M_ADDR[11:2]];

    // Memory model: each word holds the constant 0x5A000000 | byte address until written.
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | (i << 2);
            mem_init <= 1'b1;
        end else begin
            if (M_REQ) begin
                if (ack_cnt != 0 && M_ADDR != held_addr) unstable <= unstable + 1;
                held_addr <= M_ADDR;
            end
            if (M_REQ && !M_ACK) ack_cnt <= ack_cnt + 1;
            else                 ack_cnt <= 0;
            if (M_REQ && M_ACK) begin
                la.push_back(M_ADDR);
                lw.push_back(M_WEN);
                ld.push_back(M_DOUT);
                if (!M_WEN) mem[M_ADDR[11:2]] <= M_DOUT;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clear_log();
        la.delete();
        lw.delete();
        ld.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the access has completed.
    task automatic access(input logic wen, input logic [11:0] addr, input logic [31:0] wd,
                          output int stalls, output logic [31:0] dout);
        bit done = 1'b0;
        C_CSN = 1'b0; C_WEN = wen; C_ADDR = addr; C_DI = wd;
        stalls = 0; dout = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (!STALL) begin
                dout = C_DOUT;
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) check_eq("access_timeout", 32'(stalls), 32'd0);
        @(posedge CLK); #1;
        C_CSN = 1'b1; C_WEN = 1'b1;
    endtask

    task automatic check_entry(input int k, input logic w, input logic [11:0] a,
                               input logic [31:0] d, input bit chk_data);
        check_eq($sformatf("log%0d_wen_addr", k), {19'd0, lw[k], la[k]}, {19'd0, w, a});
        if (chk_data) check_eq($sformatf("log%0d_data", k), ld[k], d);
    endtask

    initial begin
        int          st;
        int          busy;
        logic [31:0] d;

        // Reset: all outputs idle while RST=1 and in the cycle after.
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_ctl", {28'd0, STALL, M_REQ, FLUSH_BUSY, M_WEN}, 32'h1);
        check_eq("rst_outs", C_DOUT | M_DOUT | {20'd0, M_ADDR}, 32'd0);
        check_eq("rst_cnt", {HIT_CNT, MISS_CNT}, 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check_eq("post_rst_ctl", {28'd0, STALL, M_REQ, FLUSH_BUSY, M_WEN}, 32'h1);
        check_eq("post_rst_cnt", {HIT_CNT, MISS_CNT}, 32'd0);
        @(posedge CLK); #1;

        // Clean read miss.
        clear_log();
        access(1'b1, 12'h040, 32'd0, st, d);
        check_eq("miss1_stall", 32'(st), 32'd5);
        check_eq("miss1_dout", d, 32'h5A00_0040);
        check_eq("miss1_cnt", {HIT_CNT, MISS_CNT}, {16'd0, 16'd1});
        check_eq("miss1_nwords", 32'(la.size()), 32'd4);
        for (int k = 0; k < 4; k++) check_entry(k, 1'b1, 12'h040 + 12'(4 * k), 32'd0, 1'b0);

        // Read hit.
        access(1'b1, 12'h048, 32'd0, st, d);
        check_eq("hit_stall", 32'(st), 32'd0);
        check_eq("hit_dout", d, 32'h5A00_0048);
        check_eq("hit_cnt", {16'd0, HIT_CNT}, 32'd1);

        // Write hit, then conflicting miss with dirty victim.
        access(1'b0, 12'h044, 32'hDEAD_BEEF, st, d);
        check_eq("whit_stall", 32'(st), 32'd0);
        clear_log();
        access(1'b1, 12'h440, 32'd0, st, d);
        check_eq("dirty_stall", 32'(st), 32'd9);
        check_eq("dirty_dout", d, 32'h5A00_0440);
        check_eq("dirty_cnt", {HIT_CNT, MISS_CNT}, {16'd2, 16'd2});
        check_eq("dirty_nwords", 32'(la.size()), 32'd8);
        for (int k = 0; k < 4; k++)
            check_entry(k, 1'b0, 12'h040 + 12'(4 * k),
                        (k == 1) ? 32'hDEAD_BEEF : 32'h5A00_0040 + 32'(4 * k), 1'b1);
        for (int k = 0; k < 4; k++) check_entry(4 + k, 1'b1, 12'h440 + 12'(4 * k), 32'd0, 1'b0);
        check_eq("dirty_mem", mem[12'h044 >> 2], 32'hDEAD_BEEF);

        // Clean miss with two ACK wait cycles per word.
        ack_delay = 2;
        access(1'b1, 12'h080, 32'd0, st, d);
        check_eq("slow_stall", 32'(st), 32'd13);
        check_eq("slow_dout", d, 32'h5A00_0080);
        check_eq("slow_addr_stable", 32'(unstable), 32'd0);
        ack_delay = 0;

        // Dirty lines 1 and 6, then flush.
        access(1'b0, 12'h014, 32'h1111_1111, st, d);
        check_eq("wmiss1_stall", 32'(st), 32'd5);
        access(1'b0, 12'h068, 32'h6666_6666, st, d);
        check_eq("wmiss6_stall", 32'(st), 32'd5);
        clear_log();
        FLUSH = 1'b1;
        @(posedge CLK); #1 FLUSH = 1'b0;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!FLUSH_BUSY) break;
            busy++;
        end
        check_eq("flush_busy", 32'(busy), 32'd14);
        check_eq("flush_nwords", 32'(la.size()), 32'd8);
        for (int k = 0; k < 4; k++)
            check_entry(k, 1'b0, 12'h010 + 12'(4 * k),
                        (k == 1) ? 32'h1111_1111 : 32'h5A00_0010 + 32'(4 * k), 1'b1);
        for (int k = 0; k < 4; k++)
            check_entry(4 + k, 1'b0, 12'h060 + 12'(4 * k),
                        (k == 2) ? 32'h6666_6666 : 32'h5A00_0060 + 32'(4 * k), 1'b1);
        check_eq("flush_mem6", mem[12'h068 >> 2], 32'h6666_6666);
        @(posedge CLK); #1;
        access(1'b1, 12'h014, 32'd0, st, d);
        check_eq("reread1", {st[15:0], d[15:0]}, {16'd0, 16'h1111});
        access(1'b1, 12'h068, 32'd0, st, d);
        check_eq("reread6_stall", 32'(st), 32'd0);
        check_eq("reread6_dout", d, 32'h6666_6666);
        check_eq("flush_cnt", {HIT_CNT, MISS_CNT}, {16'd4, 16'd5});

        // Reset during the second fill word abandons the transfer.
        clear_log();
        C_CSN = 1'b0; C_WEN = 1'b1; C_ADDR = 12'h100;
        @(posedge CLK);
        @(posedge CLK); #1 RST = 1'b1;
        @(negedge CLK);
        check_eq("rstmid_req", {30'd0, M_REQ, STALL}, 32'd0);
        check_eq("rstmid_words", 32'(la.size()), 32'd1);
        @(posedge CLK); #1 RST = 1'b0; C_CSN = 1'b1;
        check_eq("rstmid_cnt", {HIT_CNT, MISS_CNT}, 32'd0);
        access(1'b1, 12'h100, 32'd0, st, d);
        check_eq("rstmid_remiss", 32'(st), 32'd5);
        check_eq("rstmid_dout", d, 32'h5A00_0100);
        check_eq("rstmid_miss", {16'd0, MISS_CNT}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
